// File: rtl/render_addr_gen_pkg.sv
// Shared constants for the pixel-to-memory address generator.
// Contents: tile geometry, default map size and screen origin, memory-select
// encodings, and sprite ids.
package render_addr_gen_pkg;

  localparam int TILE_PX      = 8;
  localparam int DEF_MAP_W    = 28;
  localparam int DEF_MAP_H    = 31;
  localparam int DEF_H_ORIGIN = 208;
  localparam int DEF_V_ORIGIN = 116;
  localparam int DEF_N_SPRITE = 5;
  localparam int DEF_ANIM_DIV = 8;

  localparam logic [1:0] MEM_SEL_BLANK = 2'b00;
  localparam logic [1:0] MEM_SEL_MAP   = 2'b01;
  localparam logic [1:0] MEM_SEL_CHAR  = 2'b11;

  localparam int SPR_PACMAN = 0;
  localparam int SPR_GHOST0 = 1;
  localparam int SPR_GHOST1 = 2;
  localparam int SPR_GHOST2 = 3;
  localparam int SPR_GHOST3 = 4;

endpackage

// File: rtl/render_addr_gen_if.sv
// Pixel stream in / memory-request fields out of the render address generator.
// Signals:
//   pix_valid, pix_x, pix_y        pixel request from the sync generator
//   valid, mem_select              result qualifier and memory select
//   address_map, address_char      tile id / {sprite id, animation phase}
//   tile_offset, char_offset       {y[2:0], x[2:0]} within tile / sprite
// Modports: master drives pixels and receives results; slave is the generator.
interface render_addr_gen_if;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       valid;
  logic [1:0] mem_select;
  logic [7:0] address_map;
  logic [7:0] address_char;
  logic [5:0] tile_offset;
  logic [5:0] char_offset;

  modport master (
    output pix_valid, pix_x, pix_y,
    input  valid, mem_select, address_map, address_char, tile_offset, char_offset
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    output valid, mem_select, address_map, address_char, tile_offset, char_offset
  );
endinterface

// File: rtl/render_addr_gen_sprite_hit_unit.sv
// Combinational hit test of one map-space pixel against one 8x8 sprite.
// Ports:
//   i_mx, i_my   map-space pixel position (11 bit, only meaningful when in map)
//   i_sx, i_sy   sprite top-left in map space
//   i_en         sprite enabled
//   o_hit        pixel lies inside the sprite box
//   o_dx, o_dy   pixel position within the sprite
module sprite_hit_unit
  import render_addr_gen_pkg::*;
(
  input  logic [10:0] i_mx,
  input  logic [10:0] i_my,
  input  logic [9:0]  i_sx,
  input  logic [9:0]  i_sy,
  input  logic        i_en,
  output logic        o_hit,
  output logic [2:0]  o_dx,
  output logic [2:0]  o_dy
);

  logic [10:0] sx_e, sy_e;

  // Box bounds widened to 11 bits so a sprite near x=1023 does not wrap.
  assign sx_e = {1'b0, i_sx};
  assign sy_e = {1'b0, i_sy};

  assign o_hit = i_en
               & (i_mx >= sx_e) & (i_mx < sx_e + 11'(TILE_PX))
               & (i_my >= sy_e) & (i_my < sy_e + 11'(TILE_PX));

  // Only the low three bits of the difference matter inside an 8-pixel box.
  assign o_dx = i_mx[2:0] - i_sx[2:0];
  assign o_dy = i_my[2:0] - i_sy[2:0];

endmodule

// File: rtl/render_addr_gen.sv
// Pixel-to-memory address generator. For each visible pixel it picks either the
// map tile (tile id from the tile-map RAM) or the highest-priority sprite and
// emits select/address/offset fields two cycles later.
// Ports:
//   i_clk, i_rst_n               pixel clock, synchronous active-low reset
//   pix_bus                      pixel request in / result fields out
//   i_frame_start                latches sprite state, advances animation
//   i_sprite_x/_y/_en            per-sprite map-space position and enable
//   o_map_rd_addr                tile-map RAM address (combinational, held)
//   i_map_rd_data                tile id, one cycle after o_map_rd_addr
module render_addr_gen
  import render_addr_gen_pkg::*;
#(
  parameter int H_ORIGIN = DEF_H_ORIGIN,
  parameter int V_ORIGIN = DEF_V_ORIGIN,
  parameter int MAP_W    = DEF_MAP_W,
  parameter int MAP_H    = DEF_MAP_H,
  parameter int N_SPRITE = DEF_N_SPRITE,
  parameter int ANIM_DIV = DEF_ANIM_DIV
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  render_addr_gen_if.slave        pix_bus,
  input  logic                    i_frame_start,
  input  logic [10*N_SPRITE-1:0]  i_sprite_x,
  input  logic [10*N_SPRITE-1:0]  i_sprite_y,
  input  logic [N_SPRITE-1:0]     i_sprite_en,
  output logic [9:0]              o_map_rd_addr,
  input  logic [7:0]              i_map_rd_data
);

  localparam int FC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // S0: map-space coordinates; bit 10 set means left of / above the map.
  logic [10:0] mx, my;
  logic        in_map;
  logic [9:0]  map_addr_now, map_addr_q, map_addr_d;

  assign mx = {1'b0, pix_bus.pix_x} - 11'(H_ORIGIN);
  assign my = {1'b0, pix_bus.pix_y} - 11'(V_ORIGIN);

  assign in_map = pix_bus.pix_valid
                & ~mx[10] & (mx < 11'(MAP_W * TILE_PX))
                & ~my[10] & (my < 11'(MAP_H * TILE_PX));

  assign map_addr_now  = 10'(int'(my[10:3]) * MAP_W + int'(mx[10:3]));
  // Address goes out in the pixel's own cycle so the sync RAM answers in time for S2.
  assign o_map_rd_addr = in_map ? map_addr_now : map_addr_q;
  assign map_addr_d    = o_map_rd_addr;

  // Sprite state latched once per frame.
  logic [10*N_SPRITE-1:0] spr_x_q, spr_y_q;
  logic [N_SPRITE-1:0]    spr_en_q;
  logic [N_SPRITE-1:0]    hit;
  logic [2:0]             dx_arr [N_SPRITE];
  logic [2:0]             dy_arr [N_SPRITE];

  for (genvar g = 0; g < N_SPRITE; g++) begin : g_spr
    sprite_hit_unit u_hit (
      .i_mx  (mx),
      .i_my  (my),
      .i_sx  (spr_x_q[10*g +: 10]),
      .i_sy  (spr_y_q[10*g +: 10]),
      .i_en  (spr_en_q[g]),
      .o_hit (hit[g]),
      .o_dx  (dx_arr[g]),
      .o_dy  (dy_arr[g])
    );
  end

  // Lowest sprite index wins; scanning downward lets the lowest overwrite last.
  logic       sel_hit;
  logic [5:0] sel_id;
  logic [2:0] sel_dx, sel_dy;

  always_comb begin
    sel_hit = 1'b0;
    sel_id  = '0;
    sel_dx  = '0;
    sel_dy  = '0;
    for (int k = N_SPRITE - 1; k >= 0; k--) begin
      if (hit[k] && in_map) begin
        sel_hit = 1'b1;
        sel_id  = 6'(k);
        sel_dx  = dx_arr[k];
        sel_dy  = dy_arr[k];
      end
    end
  end

  // Animation: frame counter wraps at ANIM_DIV-1 and steps the 2-bit phase.
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]      anim_q, anim_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + FC_W'(1);
    anim_d      = anim_q;
    if (frame_cnt_q == FC_W'(ANIM_DIV - 1)) begin
      frame_cnt_d = '0;
      anim_d      = anim_q + 2'd1;
    end
  end

  // S1 and S2 pipeline registers.
  logic       v1_q, inmap1_q, hit1_q;
  logic [5:0] id1_q;
  logic [2:0] cdx1_q, cdy1_q, tx1_q, ty1_q;

  logic       valid_q;
  logic [1:0] sel_q;
  logic [7:0] amap_q, achar_q;
  logic [5:0] toff_q, coff_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      map_addr_q  <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_en_q    <= '0;
      frame_cnt_q <= '0;
      anim_q      <= '0;
      v1_q        <= 1'b0;
      inmap1_q    <= 1'b0;
      hit1_q      <= 1'b0;
      id1_q       <= '0;
      cdx1_q      <= '0;
      cdy1_q      <= '0;
      tx1_q       <= '0;
      ty1_q       <= '0;
      valid_q     <= 1'b0;
      sel_q       <= MEM_SEL_BLANK;
      amap_q      <= '0;
      achar_q     <= '0;
      toff_q      <= '0;
      coff_q      <= '0;
    end else begin
      map_addr_q <= map_addr_d;
      if (i_frame_start) begin
        spr_x_q     <= i_sprite_x;
        spr_y_q     <= i_sprite_y;
        spr_en_q    <= i_sprite_en;
        frame_cnt_q <= frame_cnt_d;
        anim_q      <= anim_d;
      end

      v1_q     <= pix_bus.pix_valid;
      inmap1_q <= in_map;
      hit1_q   <= sel_hit;
      id1_q    <= sel_id;
      cdx1_q   <= sel_dx;
      cdy1_q   <= sel_dy;
      tx1_q    <= mx[2:0];
      ty1_q    <= my[2:0];

      valid_q <= v1_q;
      sel_q   <= MEM_SEL_BLANK;
      amap_q  <= '0;
      achar_q <= '0;
      toff_q  <= '0;
      coff_q  <= '0;
      if (v1_q && inmap1_q) begin
        if (hit1_q) begin
          sel_q   <= MEM_SEL_CHAR;
          achar_q <= {id1_q, anim_q};
          coff_q  <= {cdy1_q, cdx1_q};
        end else begin
          sel_q  <= MEM_SEL_MAP;
          amap_q <= i_map_rd_data;
          toff_q <= {ty1_q, tx1_q};
        end
      end
    end
  end

  assign pix_bus.valid        = valid_q;
  assign pix_bus.mem_select   = sel_q;
  assign pix_bus.address_map  = amap_q;
  assign pix_bus.address_char = achar_q;
  assign pix_bus.tile_offset  = toff_q;
  assign pix_bus.char_offset  = coff_q;

endmodule
